// File: rtl/spi_flash_responder_if.sv
// SPI pin bundle plus the responder's status outputs.
// The master modport drives the pins; the slave modport is the flash side.
interface spi_flash_responder_if;
  logic        spi_clk;
  logic        spi_di;
  logic        spi_cs;
  logic        spi_do;
  logic        active;
  logic        cmd_strobe;
  logic [7:0]  cmd_code;
  logic [15:0] xfer_count;

  modport master (
    output spi_clk, spi_di, spi_cs,
    input  spi_do, active, cmd_strobe, cmd_code, xfer_count
  );

  modport slave (
    input  spi_clk, spi_di, spi_cs,
    output spi_do, active, cmd_strobe, cmd_code, xfer_count
  );
endinterface

// File: rtl/spi_flash_responder.sv
// SPI mode-0 responder emulating the JEDEC-ID / status / read subset of a serial flash.
// The SPI pins are oversampled in the clk domain through 2-flop synchronizers.
module spi_flash_responder #(
  parameter logic [7:0] MFR_ID     = 8'hEF,
  parameter logic [7:0] MEM_TYPE   = 8'h40,
  parameter logic [7:0] CAPACITY   = 8'h18,
  parameter logic [7:0] DEVICE_ID  = 8'h17,
  parameter logic [7:0] STATUS_REG = 8'h00,
  parameter logic [7:0] DATA_SEED  = 8'h5A
) (
  input  logic                   clk,
  input  logic                   rst_n,
  spi_flash_responder_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, RESP, IGNORE} state_t;

  // Pin order {di, cs, clk}; idle-bus values are the reset values.
  localparam logic [2:0] SYNC_INIT = 3'b110;

  logic [2:0] pin_raw;
  logic [2:0] pin_meta_reg;
  logic [2:0] pin_sync_reg;

  assign pin_raw = {bus.spi_di, bus.spi_cs, bus.spi_clk};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pin_meta_reg[gi] <= SYNC_INIT[gi];
          pin_sync_reg[gi] <= SYNC_INIT[gi];
        end else begin
          pin_meta_reg[gi] <= pin_raw[gi];
          pin_sync_reg[gi] <= pin_meta_reg[gi];
        end
      end
    end
  endgenerate

  logic sclk_s, cs_s, di_s;
  logic sclk_prev_reg, cs_prev_reg;
  logic settle_1_reg, settle_2_reg, armed_reg;

  assign sclk_s = pin_sync_reg[0];
  assign cs_s   = pin_sync_reg[1];
  assign di_s   = pin_sync_reg[2];

  // armed only counts cs=1 once the synchronizer holds real pin samples, so a
  // reset released mid-frame cannot mistake its reset value for a deselect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_prev_reg <= 1'b0;
      cs_prev_reg   <= 1'b1;
      settle_1_reg  <= 1'b0;
      settle_2_reg  <= 1'b0;
      armed_reg     <= 1'b0;
    end else begin
      sclk_prev_reg <= sclk_s;
      cs_prev_reg   <= cs_s;
      settle_1_reg  <= 1'b1;
      settle_2_reg  <= settle_1_reg;
      if (settle_2_reg && cs_s) armed_reg <= 1'b1;
    end
  end

  logic sclk_rise, sclk_fall, cs_rise, frame_start;

  assign sclk_rise   = sclk_s & ~sclk_prev_reg;
  assign sclk_fall   = ~sclk_s & sclk_prev_reg;
  assign cs_rise     = cs_s & ~cs_prev_reg;
  assign frame_start = ~cs_s & cs_prev_reg & armed_reg;

  state_t      state_reg;
  logic [6:0]  rx_shift_reg;
  logic [7:0]  tx_shift_reg;
  logic [2:0]  bit_cnt_reg;
  logic [1:0]  cnt_reg;
  logic [1:0]  idx_reg;
  logic [23:0] addr_reg;
  logic        spi_do_reg;
  logic        active_reg;
  logic        cmd_strobe_reg;
  logic [7:0]  cmd_code_reg;
  logic [15:0] xfer_count_reg;

  logic [7:0]  rx_byte;
  logic [23:0] addr_next;

  assign rx_byte   = {rx_shift_reg, di_s};
  assign addr_next = addr_reg + 24'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      rx_shift_reg   <= '0;
      tx_shift_reg   <= 8'hFF;
      bit_cnt_reg    <= '0;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      addr_reg       <= '0;
      spi_do_reg     <= 1'b1;
      active_reg     <= 1'b0;
      cmd_strobe_reg <= 1'b0;
      cmd_code_reg   <= '0;
      xfer_count_reg <= '0;
    end else begin
      cmd_strobe_reg <= 1'b0;
      if (cs_rise) begin
        // Deselect wins over any same-cycle clock edge; partial byte dropped.
        state_reg   <= IDLE;
        bit_cnt_reg <= '0;
        spi_do_reg  <= 1'b1;
        active_reg  <= 1'b0;
      end else if (state_reg == IDLE) begin
        spi_do_reg <= 1'b1;
        if (frame_start) begin
          state_reg      <= CMD;
          active_reg     <= 1'b1;
          xfer_count_reg <= '0;
          bit_cnt_reg    <= '0;
        end
      end else if (sclk_rise) begin
        rx_shift_reg <= rx_byte[6:0];
        bit_cnt_reg  <= bit_cnt_reg + 3'd1;
        if (bit_cnt_reg == 3'd7) begin
          if (xfer_count_reg != 16'hFFFF) xfer_count_reg <= xfer_count_reg + 16'd1;
          case (state_reg)
            CMD: begin
              cmd_code_reg   <= rx_byte;
              cmd_strobe_reg <= 1'b1;
              case (rx_byte)
                8'h9F:   begin state_reg <= RESP;  tx_shift_reg <= MFR_ID; idx_reg <= 2'd1; end
                8'h05:   begin state_reg <= RESP;  tx_shift_reg <= STATUS_REG; end
                8'hAB:   begin state_reg <= DUMMY; cnt_reg <= 2'd3; end
                8'h03:   begin state_reg <= ADDR;  cnt_reg <= 2'd3; end
                default: state_reg <= IGNORE;
              endcase
            end
            ADDR: begin
              addr_reg <= {addr_reg[15:0], rx_byte};
              cnt_reg  <= cnt_reg - 2'd1;
              if (cnt_reg == 2'd1) begin
                state_reg    <= RESP;
                tx_shift_reg <= rx_byte ^ DATA_SEED;
              end
            end
            DUMMY: begin
              cnt_reg <= cnt_reg - 2'd1;
              if (cnt_reg == 2'd1) begin
                state_reg    <= RESP;
                tx_shift_reg <= DEVICE_ID;
              end
            end
            RESP: begin
              case (cmd_code_reg)
                8'h9F: begin
                  case (idx_reg)
                    2'd1:    tx_shift_reg <= MEM_TYPE;
                    2'd2:    tx_shift_reg <= CAPACITY;
                    default: tx_shift_reg <= 8'hFF;
                  endcase
                  if (idx_reg != 2'd3) idx_reg <= idx_reg + 2'd1;
                end
                8'h05: tx_shift_reg <= STATUS_REG;
                8'hAB: tx_shift_reg <= DEVICE_ID;
                8'h03: begin
                  addr_reg     <= addr_next;
                  tx_shift_reg <= addr_next[7:0] ^ DATA_SEED;
                end
                default: tx_shift_reg <= 8'hFF;
              endcase
            end
            default: ;
          endcase
        end
      end else if (sclk_fall && state_reg == RESP) begin
        spi_do_reg   <= tx_shift_reg[7];
        tx_shift_reg <= {tx_shift_reg[6:0], 1'b1};
      end
    end
  end

  assign bus.spi_do     = spi_do_reg;
  assign bus.active     = active_reg;
  assign bus.cmd_strobe = cmd_strobe_reg;
  assign bus.cmd_code   = cmd_code_reg;
  assign bus.xfer_count = xfer_count_reg;

endmodule
